pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 125 ++++++++++++
 tb/tb_pong_game_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: start/serve/game-over sequencing, BCD hit score,
// ball count and the refresh-tick hold timer used between balls and after game over.
module pong_game_ctrl #(
  parameter int BALLS_INIT = 3,
  parameter int HOLD_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       hit,
  input  logic       miss,
  output logic       graph_still,
  output logic [3:0] score_d1,
  output logic [3:0] score_d0,
  output logic [1:0] balls,
  output logic [1:0] game_state,
  output logic       game_over
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t     state, state_next;
  logic [6:0] timer;
  logic       refr_tick, timer_up, timer_start, any_btn;
  logic       score_clr, score_inc, balls_load, balls_dec, over_set;

  assign refr_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign timer_up   = (timer == 7'd0);
  assign any_btn    = (|btn1) | (|btn2);
  assign game_state = state;

  // hit and miss are levels, so they are only acted on while in PLAY
  always_comb begin
    state_next  = state;
    graph_still = 1'b1;
    timer_start = 1'b0;
    score_clr   = 1'b0;
    score_inc   = 1'b0;
    balls_load  = 1'b0;
    balls_dec   = 1'b0;
    over_set    = 1'b0;
    case (state)
      NEWGAME: begin
        if (any_btn) begin
          state_next = PLAY;
          score_clr  = 1'b1;
          balls_load = 1'b1;
        end
      end
      PLAY: begin
        graph_still = 1'b0;
        score_inc   = hit;
        if (miss) begin
          timer_start = 1'b1;
          balls_dec   = 1'b1;
          if (balls > 2'd1) begin
            state_next = NEWBALL;
          end else begin
            state_next = OVER;
            over_set   = 1'b1;
          end
        end
      end
      NEWBALL: begin
        if (timer_up && any_btn) state_next = PLAY;
      end
      OVER: begin
        if (timer_up) state_next = NEWGAME;
      end
      default: state_next = NEWGAME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= NEWGAME;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      game_over <= over_set;
    end
  end

  // a load on the same clk as a refresh tick wins over the decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 7'd0;
    end else if (timer_start) begin
      timer <= 7'(HOLD_TICKS);
    end else if (refr_tick && !timer_up) begin
      timer <= timer - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || score_clr) begin
      score_d1 <= 4'd0;
      score_d0 <= 4'd0;
    end else if (score_inc && !(score_d1 == 4'd9 && score_d0 == 4'd9)) begin
      if (score_d0 == 4'd9) begin
        score_d0 <= 4'd0;
        score_d1 <= score_d1 + 4'd1;
      end else begin
        score_d0 <= score_d0 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || balls_load) begin
      balls <= 2'(BALLS_INIT);
    end else if (balls_dec && balls != 2'd0) begin
      balls <= balls - 2'd1;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: a directed vector table for the
// basic flow, then hand sequences for the hold timer, game over, saturation and reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn1, btn2;
  logic [9:0] pix_x, pix_y;
  logic       hit, miss;
  logic       graph_still, game_over;
  logic [3:0] score_d1, score_d0;
  logic [1:0] balls, game_state;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] S_NG = 2'b00, S_PL = 2'b01, S_NB = 2'b10, S_OV = 2'b11;

  typedef struct {
    logic [1:0] b1, b2;
    logic       hit, miss, rst, tick;
    logic [1:0] st;
    logic [3:0] d1, d0;
    logic [1:0] bl;
    logic       still, over;
  } vec_t;

  vec_t vq[$];

  pong_game_ctrl dut (
    .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2),
    .pix_x(pix_x), .pix_y(pix_y), .hit(hit), .miss(miss),
    .graph_still(graph_still), .score_d1(score_d1), .score_d0(score_d0),
    .balls(balls), .game_state(game_state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic [1:0] b1, input logic [1:0] b2,
                              input logic h, input logic m, input logic r,
                              input logic [1:0] st, input int score,
                              input logic [1:0] bl, input logic still, input logic over);
    vec_t v;
    v.b1 = b1; v.b2 = b2; v.hit = h; v.miss = m; v.rst = r; v.tick = 1'b0;
    v.st = st; v.d1 = 4'(score / 10); v.d0 = 4'(score % 10);
    v.bl = bl; v.still = still; v.over = over;
    vq.push_back(v);
  endfunction

  // Drive one clk worth of inputs, then sample 1 time unit after the edge
  task automatic apply_stimulus(input logic [1:0] b1, input logic [1:0] b2,
                                input logic h, input logic m, input logic r,
                                input logic tk);
    btn1 = b1; btn2 = b2; hit = h; miss = m; reset = r;
    pix_y = tk ? 10'd481 : 10'd100;
    pix_x = tk ? 10'd0 : 10'd5;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [1:0] st,
                              input int score, input logic [1:0] bl,
                              input logic still, input logic over);
    logic [3:0] d1, d0;
    d1 = 4'(score / 10);
    d0 = 4'(score % 10);
    checks++;
    if (game_state !== st || score_d1 !== d1 || score_d0 !== d0 ||
        balls !== bl || graph_still !== still || game_over !== over) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b score=%h%h balls=%0d still=%b over=%b, want state=%b score=%h%h balls=%0d still=%b over=%b",
               name, game_state, score_d1, score_d0, balls, graph_still, game_over,
               st, d1, d0, bl, still, over);
    end
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    btn1 = 2'b00; btn2 = 2'b00; hit = 1'b0; miss = 1'b0; reset = 1'b1;
    pix_x = 10'd5; pix_y = 10'd100;

    // reset, ignored hit/miss outside PLAY, start, 12 hits, miss held 5 clks
    add(2'b00, 2'b00, 0, 0, 1, S_NG, 0, 2'd3, 1, 0);
    add(2'b00, 2'b00, 0, 0, 0, S_NG, 0, 2'd3, 1, 0);
    add(2'b00, 2'b00, 1, 0, 0, S_NG, 0, 2'd3, 1, 0);
    add(2'b00, 2'b00, 0, 1, 0, S_NG, 0, 2'd3, 1, 0);
    add(2'b01, 2'b00, 0, 0, 0, S_PL, 0, 2'd3, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, S_PL, 0, 2'd3, 0, 0);
    for (int i = 1; i <= 12; i++) add(2'b00, 2'b00, 1, 0, 0, S_PL, i, 2'd3, 0, 0);
    add(2'b00, 2'b00, 0, 0, 0, S_PL, 12, 2'd3, 0, 0);
    for (int i = 0; i < 5; i++) add(2'b00, 2'b00, 0, 1, 0, S_NB, 12, 2'd2, 1, 0);
    add(2'b00, 2'b00, 1, 0, 0, S_NB, 12, 2'd2, 1, 0);
    add(2'b00, 2'b10, 0, 0, 0, S_NB, 12, 2'd2, 1, 0);
    add(2'b00, 2'b00, 0, 0, 0, S_NB, 12, 2'd2, 1, 0);

    @(negedge clk);
    foreach (vq[i]) begin
      apply_stimulus(vq[i].b1, vq[i].b2, vq[i].hit, vq[i].miss, vq[i].rst, vq[i].tick);
      checks++;
      if (game_state !== vq[i].st || score_d1 !== vq[i].d1 || score_d0 !== vq[i].d0 ||
          balls !== vq[i].bl || graph_still !== vq[i].still || game_over !== vq[i].over) begin
        errors++;
        $display("[TB] FAIL vec%0d: got state=%b score=%h%h balls=%0d still=%b over=%b, want state=%b score=%h%h balls=%0d still=%b over=%b",
                 i, game_state, score_d1, score_d0, balls, graph_still, game_over,
                 vq[i].st, vq[i].d1, vq[i].d0, vq[i].bl, vq[i].still, vq[i].over);
      end
    end

    // NEWBALL hold: a press one tick early is ignored, after 120 ticks it serves
    idle_ticks(119);
    apply_stimulus(2'b00, 2'b10, 0, 0, 0, 0);
    check_output("nb_early_btn", S_NB, 12, 2'd2, 1, 0);
    idle_ticks(1);
    apply_stimulus(2'b00, 2'b10, 0, 0, 0, 0);
    check_output("nb_serve", S_PL, 12, 2'd2, 0, 0);

    // hit and miss together, with a refresh tick on the same clk as the load
    apply_stimulus(2'b00, 2'b00, 1, 1, 0, 1);
    check_output("hit_and_miss", S_NB, 13, 2'd1, 1, 0);
    idle_ticks(119);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0);
    check_output("load_beats_tick", S_NB, 13, 2'd1, 1, 0);
    idle_ticks(1);
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0);
    check_output("serve_last_ball", S_PL, 13, 2'd1, 0, 0);

    // last ball lost: one-clk game_over, buttons ignored, hold then NEWGAME
    apply_stimulus(2'b00, 2'b00, 0, 1, 0, 0);
    check_output("over_entry", S_OV, 13, 2'd0, 1, 1);
    apply_stimulus(2'b00, 2'b00, 0, 1, 0, 0);
    check_output("over_pulse_end", S_OV, 13, 2'd0, 1, 0);
    apply_stimulus(2'b11, 2'b11, 1, 0, 0, 1);
    check_output("over_btn_ignored", S_OV, 13, 2'd0, 1, 0);
    idle_ticks(118);
    check_output("over_hold", S_OV, 13, 2'd0, 1, 0);
    idle_ticks(1);
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0);
    check_output("over_to_newgame", S_NG, 13, 2'd0, 1, 0);
    apply_stimulus(2'b10, 2'b00, 0, 0, 0, 0);
    check_output("restart", S_PL, 0, 2'd3, 0, 0);

    // score saturates at 99
    for (int i = 0; i < 99; i++) apply_stimulus(2'b00, 2'b00, 1, 0, 0, 0);
    check_output("score_99", S_PL, 99, 2'd3, 0, 0);
    apply_stimulus(2'b00, 2'b00, 1, 0, 0, 0);
    check_output("score_sat", S_PL, 99, 2'd3, 0, 0);

    // reset in the middle of a NEWBALL hold
    apply_stimulus(2'b00, 2'b00, 0, 1, 0, 0);
    check_output("miss_to_nb", S_NB, 99, 2'd2, 1, 0);
    idle_ticks(60);
    apply_stimulus(2'b01, 2'b00, 0, 1, 1, 1);
    check_output("reset_mid_hold", S_NG, 0, 2'd3, 1, 0);
    checks++;
    if (dut.timer !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_timer: got %0d want 0", dut.timer);
    end

    // reset beats a last-ball miss: no game_over pulse
    apply_stimulus(2'b01, 2'b00, 0, 0, 0, 0);
    check_output("start_again", S_PL, 0, 2'd3, 0, 0);
    apply_stimulus(2'b00, 2'b00, 1, 1, 1, 0);
    check_output("reset_in_play", S_NG, 0, 2'd3, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
